// File: rtl/cfg_pkg.sv
// System-wide configuration shared by the stk pipeline and its engines.
package cfg_pkg;
  localparam int unsigned ENGS_N = 4;
endpackage

// File: rtl/stk_cmd_init_pkg.sv
// Local types for the stk command initiator.
package stk_cmd_init_pkg;
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } state_e;
endpackage

// File: rtl/stk_pkg.sv
// stk command encoding and helpers shared by stk and its command initiators.
package stk_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_PEEK = 3'd3,
    OP_CLR  = 3'd4
  } opcode_t;

  typedef struct packed {
    opcode_t      opcode;
    logic [127:0] dat;
  } cmd_t;

  // Opcodes for which stk later returns exactly one response beat.
  function automatic logic opcode_has_rsp(input opcode_t op);
    return (op == OP_POP) || (op == OP_PEEK);
  endfunction
endpackage

// File: rtl/stk_cmd_init_rsp_fifo.sv
// Small FWFT response FIFO with registered storage; push and pop may coincide even when full.
module stk_cmd_init_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [Width-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [Width-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CntW'(Depth));
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

// File: rtl/stk_cmd_init.sv
// Per-engine stk command initiator: issues client commands to stk, holds them until ack, and
// buffers this engine's responses behind a credit scheme since stk responses cannot stall.
module stk_cmd_init
  import stk_pkg::*;
  import stk_cmd_init_pkg::*;
#(
  parameter int unsigned ENG_ID        = 0,
  parameter int unsigned RSP_FIFO_N    = 4,
  parameter int unsigned ACK_TIMEOUT_N = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_vld,
  input  opcode_t                   i_req_opcode,
  input  logic [127:0]              i_req_dat,
  output logic                      o_req_rdy,
  output opcode_t                   o_cmd_opcode,
  output logic [127:0]              o_cmd_dat,
  input  logic                      i_cmd_ack,
  input  logic [cfg_pkg::ENGS_N-1:0] i_rsp_vld,
  input  logic [127:0]              i_rsp_dat,
  output logic                      o_rsp_vld,
  output logic [127:0]              o_rsp_dat,
  input  logic                      i_rsp_rdy,
  output logic                      o_busy,
  output logic                      o_err_timeout,
  output logic                      o_err_unexp
);
  localparam int unsigned CredW = $clog2(RSP_FIFO_N + 1);
  localparam int unsigned TmoW  = $clog2(ACK_TIMEOUT_N);
  localparam logic [cfg_pkg::ENGS_N-1:0] EngMask = cfg_pkg::ENGS_N'(1) << ENG_ID;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CredW-1:0] cred_q, cred_d;
  logic [CredW-1:0] outst_q, outst_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             err_to_q, err_to_d;
  logic             err_unexp_q, err_unexp_d;

  logic             issue, acked, accept, req_has_rsp, waiting;
  logic             rsp_hit, rsp_push, rsp_pop;
  logic             fifo_full, fifo_empty;
  logic [CredW-1:0] fifo_count;

  always_comb begin
    issue       = (state_q == StIssue);
    acked       = issue & i_cmd_ack;
    waiting     = issue & ~i_cmd_ack;
    req_has_rsp = opcode_has_rsp(i_req_opcode);
    o_req_rdy   = (~issue | acked) & (~req_has_rsp | (cred_q != '0));
    accept      = i_req_vld & o_req_rdy;
    rsp_hit     = |(i_rsp_vld & EngMask);
    rsp_pop     = ~fifo_empty & i_rsp_rdy;
    // Credits make overflow impossible; the full gate only protects against a broken stk.
    rsp_push    = rsp_hit & (outst_q != '0) & (~fifo_full | rsp_pop);
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (i_cmd_ack) state_d = accept ? StIssue : StIdle;
    endcase
    if (accept) cmd_d = '{opcode: i_req_opcode, dat: i_req_dat};

    cred_d  = cred_q - CredW'(accept & req_has_rsp) + CredW'(rsp_pop);
    outst_d = outst_q + CredW'(acked & opcode_has_rsp(cmd_q.opcode))
                      - CredW'(rsp_hit & (outst_q != '0));

    tmo_d = '0;
    if (waiting) tmo_d = (tmo_q == TmoW'(ACK_TIMEOUT_N - 1)) ? tmo_q : tmo_q + TmoW'(1);
    err_to_d    = err_to_q | (waiting & (tmo_d == TmoW'(ACK_TIMEOUT_N - 1)));
    err_unexp_d = err_unexp_q | (rsp_hit & (outst_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= '{opcode: OP_NOP, dat: '0};
      cred_q      <= CredW'(RSP_FIFO_N);
      outst_q     <= '0;
      tmo_q       <= '0;
      err_to_q    <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cred_q      <= cred_d;
      outst_q     <= outst_d;
      tmo_q       <= tmo_d;
      err_to_q    <= err_to_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  stk_cmd_init_rsp_fifo #(
    .Depth (RSP_FIFO_N),
    .Width (128)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .wdata_i (i_rsp_dat),
    .pop_i   (rsp_pop),
    .rdata_o (o_rsp_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    o_cmd_opcode  = issue ? cmd_q.opcode : OP_NOP;
    o_cmd_dat     = cmd_q.dat;
    o_rsp_vld     = ~fifo_empty;
    o_busy        = issue | (outst_q != '0) | (fifo_count != '0);
    o_err_timeout = err_to_q;
    o_err_unexp   = err_unexp_q;
  end
endmodule

// File: tb/tb_stk_cmd_init.sv
// Randomized and directed bench for stk_cmd_init against a transaction-level reference model.
module tb_stk_cmd_init;
  import stk_pkg::*;

  localparam int ENG   = 1;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic         clk, rst;
  logic         i_req_vld, o_req_rdy, i_cmd_ack, o_rsp_vld, i_rsp_rdy;
  opcode_t      i_req_opcode, o_cmd_opcode;
  logic [127:0] i_req_dat, o_cmd_dat, i_rsp_dat, o_rsp_dat;
  logic [3:0]   i_rsp_vld;
  logic         o_busy, o_err_timeout, o_err_unexp;

  stk_cmd_init #(
    .ENG_ID        (ENG),
    .RSP_FIFO_N    (DEPTH),
    .ACK_TIMEOUT_N (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_vld     (i_req_vld),
    .i_req_opcode  (i_req_opcode),
    .i_req_dat     (i_req_dat),
    .o_req_rdy     (o_req_rdy),
    .o_cmd_opcode  (o_cmd_opcode),
    .o_cmd_dat     (o_cmd_dat),
    .i_cmd_ack     (i_cmd_ack),
    .i_rsp_vld     (i_rsp_vld),
    .i_rsp_dat     (i_rsp_dat),
    .o_rsp_vld     (o_rsp_vld),
    .o_rsp_dat     (o_rsp_dat),
    .i_rsp_rdy     (i_rsp_rdy),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout),
    .o_err_unexp   (o_err_unexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending command, a credit pool, outstanding count, response queue.
  bit           m_pend;
  opcode_t      m_op;
  logic [127:0] m_dat;
  int           m_cred, m_outst, m_wait, owed;
  bit           m_err_to, m_err_unexp;
  logic [127:0] m_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_has_rsp(input opcode_t op);
    return op == OP_POP || op == OP_PEEK;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    m_pend = 0; m_op = OP_NOP; m_dat = '0; m_cred = DEPTH; m_outst = 0; m_wait = 0;
    owed = 0; m_err_to = 0; m_err_unexp = 0;
    m_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req_vld = 0; i_req_opcode = OP_NOP; i_req_dat = '0; i_cmd_ack = 0;
    i_rsp_vld = '0; i_rsp_dat = '0; i_rsp_rdy = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check_eq("rst_op", 128'(o_cmd_opcode), 128'(OP_NOP));
    check_eq("rst_dat", o_cmd_dat, '0);
    check_eq("rst_rsp_vld", 128'(o_rsp_vld), 0);
    check_eq("rst_rsp_dat", o_rsp_dat, '0);
    check_eq("rst_busy", 128'(o_busy), 0);
    check_eq("rst_err_to", 128'(o_err_timeout), 0);
    check_eq("rst_err_unexp", 128'(o_err_unexp), 0);
  endtask

  // One clock: drive inputs, compare all outputs at negedge, then advance the model at posedge.
  task automatic step(input logic vld, input opcode_t op, input logic [127:0] dat,
                      input logic ack, input logic [3:0] rv, input logic [127:0] rd,
                      input logic rr);
    bit exp_rdy, acc, acked, pop;
    i_req_vld = vld; i_req_opcode = op; i_req_dat = dat; i_cmd_ack = ack;
    i_rsp_vld = rv; i_rsp_dat = rd; i_rsp_rdy = rr;
    @(negedge clk);
    exp_rdy = (!m_pend || ack) && (!m_has_rsp(op) || m_cred > 0);
    check_eq("req_rdy", 128'(o_req_rdy), 128'(exp_rdy));
    check_eq("cmd_op", 128'(o_cmd_opcode), 128'(m_pend ? m_op : OP_NOP));
    if (m_pend) check_eq("cmd_dat", o_cmd_dat, m_dat);
    check_eq("rsp_vld", 128'(o_rsp_vld), 128'(m_q.size() > 0));
    if (m_q.size() > 0) check_eq("rsp_dat", o_rsp_dat, m_q[0]);
    check_eq("busy", 128'(o_busy), 128'(m_pend || m_outst > 0 || m_q.size() > 0));
    check_eq("err_to", 128'(o_err_timeout), 128'(m_err_to));
    check_eq("err_unexp", 128'(o_err_unexp), 128'(m_err_unexp));
    @(posedge clk);
    acc   = vld && exp_rdy;
    acked = m_pend && ack;
    pop   = m_q.size() > 0 && rr;
    if (m_pend && !ack) begin
      m_wait++;
      if (m_wait >= TMO - 1) m_err_to = 1;
    end else m_wait = 0;
    if (pop) begin
      void'(m_q.pop_front());
      m_cred++;
    end
    if (rv[ENG]) begin
      if (owed > 0) owed--;
      if (m_outst > 0) begin
        m_q.push_back(rd);
        m_outst--;
      end else m_err_unexp = 1;
    end
    if (acked && m_has_rsp(m_op)) begin
      m_outst++;
      owed++;
    end
    if (acc) begin
      if (m_has_rsp(op)) m_cred--;
      m_pend = 1; m_op = op; m_dat = dat;
    end else if (acked) m_pend = 0;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (m_pend || m_outst > 0 || m_q.size() > 0); i++)
      step(0, OP_NOP, '0, 1, (owed > 0) ? 4'b0010 : 4'b0000, rnd128(), 1);
    check_eq("drain_idle", 128'(o_busy), 0);
  endtask

  initial begin
    logic [127:0] d;
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    // Single command with delayed ack.
    step(1, OP_PUSH, 128'h1234, 0, '0, '0, 0);
    check_eq("single_op", 128'(o_cmd_opcode), 128'(OP_PUSH));
    check_eq("single_dat", o_cmd_dat, 128'h1234);
    repeat (3) step(0, OP_NOP, '0, 0, '0, '0, 0);
    step(0, OP_NOP, '0, 1, '0, '0, 0);
    check_eq("single_nop", 128'(o_cmd_opcode), 128'(OP_NOP));

    // Back-to-back pushes, ack held high.
    for (int i = 0; i < 3; i++) begin
      d = rnd128();
      step(1, OP_PUSH, d, 1, '0, '0, 0);
      check_eq("b2b_op", 128'(o_cmd_opcode), 128'(OP_PUSH));
      check_eq("b2b_dat", o_cmd_dat, d);
    end
    step(0, OP_NOP, '0, 1, '0, '0, 0);

    // Credit stall: five POPs with the client not draining responses.
    for (int i = 0; i < 5; i++) step(1, OP_POP, 128'(i), 1, '0, '0, 0);
    check_eq("stall_rdy", 128'(o_req_rdy), 0);
    for (int i = 0; i < 4; i++) step(1, OP_POP, 128'd4, 0, 4'b0010, rnd128(), 0);
    check_eq("stall_rdy2", 128'(o_req_rdy), 0);
    step(1, OP_POP, 128'd4, 0, '0, '0, 1);
    step(1, OP_POP, 128'd4, 1, '0, '0, 0);
    check_eq("release_op", 128'(o_cmd_opcode), 128'(OP_POP));
    // Pop and push together while the FIFO holds three entries.
    step(0, OP_NOP, '0, 1, '0, '0, 0);
    step(0, OP_NOP, '0, 0, 4'b0010, rnd128(), 1);
    drain();

    // Engine filter: another engine's bit is ignored; ours with nothing outstanding is flagged.
    step(0, OP_NOP, '0, 0, 4'b0100, rnd128(), 0);
    check_eq("filter_unexp", 128'(o_err_unexp), 0);
    step(0, OP_NOP, '0, 0, 4'b0010, rnd128(), 0);
    check_eq("unexp_set", 128'(o_err_unexp), 1);
    repeat (2) step(0, OP_NOP, '0, 0, '0, '0, 0);
    do_reset();

    // Random traffic with a well-behaved stk plus noise on other engines' response bits.
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] rv;
      rv      = 4'($urandom) & 4'b1101 & {4{$urandom_range(0, 3) == 0}};
      rv[ENG] = (owed > 0) && ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 3) != 0, opcode_t'($urandom_range(1, 4)), rnd128(),
           $urandom_range(0, 2) != 0, rv, rnd128(), $urandom_range(0, 1) == 1);
    end
    drain();
    do_reset();

    // Ack timeout, then reset with the command still pending.
    step(1, OP_PUSH, 128'hbeef, 0, '0, '0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, OP_NOP, '0, 0, '0, '0, 0);
      if (k == 6) check_eq("tmo_before", 128'(o_err_timeout), 0);
      if (k == 7) check_eq("tmo_at", 128'(o_err_timeout), 1);
    end
    check_eq("tmo_hold_op", 128'(o_cmd_opcode), 128'(OP_PUSH));
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stk_cmd_init.md
Name: stk_cmd_init

Overview:
- Per-engine command initiator for the stk stack pipeline: the requester end of one stk command/response port pair.
- Accepts client requests over valid/ready and drives stk opcode/data, holding them until stk acknowledges.
- Captures this engine's responses into a local FIFO and returns them to the client with backpressure.
- Credit-limits response-producing commands, since stk responses cannot be stalled. One instance per engine (cfg_pkg::ENGS_N instances) in front of stk.

Parameters:
- ENG_ID, 0, engine index; selects bit of i_rsp_vld.
- RSP_FIFO_N, 4, response FIFO depth and response-credit pool (power of 2, >=2).
- ACK_TIMEOUT_N, 1024, cycles a command may wait for ack before o_err_timeout sets.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_req_vld  in  1  client request valid.
- i_req_opcode  in  stk_pkg::opcode_t  client opcode; never OP_NOP when valid.
- i_req_dat  in  128  client data.
- o_req_rdy  out  1  request accepted when vld&rdy.
- o_cmd_opcode  out  stk_pkg::opcode_t  to stk i_cmd_opcode[ENG_ID].
- o_cmd_dat  out  128  to stk i_cmd_dat[ENG_ID].
- i_cmd_ack  in  1  from stk o_cmd_ack[ENG_ID].
- i_rsp_vld  in  cfg_pkg::ENGS_N  stk o_rsp_vld.
- i_rsp_dat  in  128  stk o_rsp_dat.
- o_rsp_vld  out  1  client response valid.
- o_rsp_dat  out  128  client response data.
- i_rsp_rdy  in  1  client response ready.
- o_busy  out  1  command pending or responses outstanding.
- o_err_timeout  out  1  sticky ack timeout.
- o_err_unexp  out  1  sticky: response arrived with zero outstanding.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: o_cmd_opcode=OP_NOP, o_cmd_dat=0, o_rsp_vld=0, o_rsp_dat=0, o_busy=0, both err=0, credits=RSP_FIFO_N, FIFO empty, state IDLE.
- FSM, 2 states:
  - IDLE: o_cmd_opcode=OP_NOP.
  - ISSUE: o_cmd_opcode/o_cmd_dat driven from the command register and held stable until i_cmd_ack.
- Acceptance:
  - o_req_rdy = (IDLE | (ISSUE & i_cmd_ack)) & (!stk_pkg::opcode_has_rsp(i_req_opcode) | credits!=0).
  - Acceptance in cycle N loads the register; the opcode appears at N+1 (state ISSUE).
  - Ack with no new acceptance -> IDLE; opcode returns to OP_NOP at N+1.
  - Ack plus acceptance in the same cycle -> stay ISSUE with the new command (back-to-back, no bubble).
  - i_cmd_ack while IDLE is ignored.
- Credits:
  - Decrement at acceptance of an opcode_has_rsp command.
  - Increment on a FIFO pop (o_rsp_vld & i_rsp_rdy).
  - A simultaneous decrement and increment nets zero.
  - Range 0..RSP_FIFO_N, width $clog2(RSP_FIFO_N+1).
- Outstanding count:
  - Increments on acked opcode_has_rsp commands.
  - Decrements on i_rsp_vld[ENG_ID].
  - Simultaneous increment and decrement nets zero.
- Responses:
  - i_rsp_vld[ENG_ID] in cycle N writes i_rsp_dat into the FIFO; o_rsp_vld may assert at N+1 (no bypass).
  - The credit scheme guarantees no overflow.
  - A response arriving with outstanding==0 is dropped and sets o_err_unexp.
- FIFO: push and pop in the same cycle is legal at any occupancy, including full. Output is registered and FWFT.
- Timeout:
  - Counter runs while ISSUE & !i_cmd_ack and clears on ack.
  - Reaching ACK_TIMEOUT_N-1 sets o_err_timeout (sticky until rst); the command remains held.
- o_busy = ISSUE | outstanding!=0 | FIFO non-empty.
- rst mid-operation: all state is discarded, including in-flight commands and buffered responses. Responses from stk for pre-reset commands raise o_err_unexp; the integrator resets stk concurrently.

Decomposition:
- stk_pkg additions:
  - function opcode_has_rsp(opcode_t) returning 1 for response-producing opcodes.
  - typedef cmd_t {opcode_t opcode; logic [127:0] dat}.
- Sub-module stk_cmd_init_rsp_fifo:
  - Parameterised by depth and width.
  - Synchronous active-high reset.
  - Ports: push, pop, full, empty, count.

Test Plan:
- Single: after reset, PUSH with dat=0x1234 accepted at N -> o_cmd_opcode=PUSH, dat 0x1234 at N+1. Hold ack low 3 cycles, then ack -> OP_NOP next cycle, credits unchanged.
- Back-to-back: 3 PUSHes with ack held high -> three consecutive opcode cycles, no NOP bubble; o_req_rdy high throughout.
- Credit stall: RSP_FIFO_N=4, 5 POPs, i_rsp_rdy=0 -> 4 accepted, 5th stalls (o_req_rdy=0). After stk returns 4 responses, popping one releases the 5th.
- Full concurrent: FIFO full, response push and client pop in the same cycle -> count stays 4, data order preserved, o_err_unexp=0.
- Unexpected/engine filter:
  - i_rsp_vld bit ENG_ID+1 pulsed -> ignored.
  - Bit ENG_ID with outstanding=0 -> dropped, o_err_unexp=1 until rst.
- Timeout/reset: ACK_TIMEOUT_N=8, ack withheld -> o_err_timeout=1 at the 8th ISSUE cycle. rst asserted -> next cycle all outputs at reset values.
